// File: rtl/ladybird_config.sv
// rtl/ladybird_config.sv - shared core configuration: XLEN, SRAM responder response and state types
package ladybird_config;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } sram_resp_t;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } sram_state_t;

endpackage

// File: rtl/ladybird_sram_responder_if.sv
// rtl/ladybird_sram_responder_if.sv - request/response bus between an initiator and the SRAM responder
interface ladybird_sram_responder_if;
  import ladybird_config::*;

  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_we;
  logic [XLEN/8-1:0] req_strb;
  logic [XLEN-1:0]   req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_strb, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_strb, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/ladybird_resp_fifo.sv
// rtl/ladybird_resp_fifo.sv - small ring-buffer FIFO holding responses until the initiator takes them
module ladybird_resp_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage; the caller's credit scheme guarantees push never hits a full FIFO
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  // Pointers and occupancy, cleared so queued entries vanish on reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign head  = store[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ladybird_sram_responder.sv
// rtl/ladybird_sram_responder.sv - word-addressed SRAM bus responder; LADYBIRD_SRAM_INIT_CLEAR_EN zeroes memory after reset
module ladybird_sram_responder
  import ladybird_config::*;
#(
  parameter int              DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              LATENCY     = 1,
  parameter int              RESP_DEPTH  = 2
) (
  input logic                       clk,
  input logic                       nrst,
  ladybird_sram_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic       valid;
    sram_resp_t resp;
  } pipe_t;

  sram_state_t     state;
  logic [CW-1:0]   outstanding;
  pipe_t           pipe [LATENCY];
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] offset;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            accept;
  logic            pop;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  sram_resp_t      fifo_head;
`ifdef LADYBIRD_SRAM_INIT_CLEAR_EN
  logic [AW-1:0]   clr_idx;
`endif

  // Range check on the full offset first, then truncate so nothing aliases
  assign offset   = bus.req_addr - BASE_ADDR;
  assign in_range = (bus.req_addr >= BASE_ADDR) && ((offset >> 2) < XLEN'(DEPTH_WORDS));
  assign idx      = AW'(offset >> 2);

  // Ready depends only on registered state so it never loops through resp_ready or req_valid
  assign bus.req_ready = (state == SERVE) && (outstanding < CW'(RESP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = (fifo_count != '0) && bus.resp_ready;

  assign bus.resp_valid = !fifo_empty;
  assign bus.resp_data  = fifo_empty ? '0 : fifo_head.data;
  assign bus.resp_err   = !fifo_empty && fifo_head.err;

  // Control FSM: INIT to SERVE sequencing plus the in-flight/queued response credit count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= INIT;
      outstanding <= '0;
`ifdef LADYBIRD_SRAM_INIT_CLEAR_EN
      clr_idx     <= '0;
`endif
    end else begin
      case (state)
        INIT: begin
`ifdef LADYBIRD_SRAM_INIT_CLEAR_EN
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH_WORDS - 1)) state <= SERVE;
`else
          state <= SERVE;
`endif
        end
        default: state <= SERVE;
      endcase
      if (accept && !pop)      outstanding <= outstanding + 1'b1;
      else if (!accept && pop) outstanding <= outstanding - 1'b1;
    end
  end

  // SRAM array writes: byte-masked stores, and the word-per-cycle clear while in INIT
  always_ff @(posedge clk) begin
`ifdef LADYBIRD_SRAM_INIT_CLEAR_EN
    if (state == INIT) mem[clr_idx] <= '0;
`endif
    if (accept && bus.req_we && in_range) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (bus.req_strb[b]) mem[idx][8*b +: 8] <= bus.req_data[8*b +: 8];
      end
    end
  end

  // Latency pipeline: stage 0 captures read data or error at acceptance, later stages shift
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
    end else begin
      pipe[0].valid     <= accept;
      pipe[0].resp.err  <= !in_range;
      pipe[0].resp.data <= (accept && in_range && !bus.req_we) ? mem[idx] : '0;
      for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  ladybird_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (sram_resp_t)
  ) u_resp_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (pipe[LATENCY-1].valid),
    .push_data (pipe[LATENCY-1].resp),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ladybird_sram_responder.sv
// tb/tb_ladybird_sram_responder.sv - self-checking bench for ladybird_sram_responder
module tb_ladybird_sram_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          LAT   = 1;
  localparam int          RD    = 2;
`ifdef LADYBIRD_SRAM_INIT_CLEAR_EN
  localparam int          INIT_CYC = DEPTH;
`else
  localparam int          INIT_CYC = 1;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   cyc  = 0;
  int   n_vec = 0;
  int   n_err = 0;

  ladybird_sram_responder_if bus ();

  ladybird_sram_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT),
    .RESP_DEPTH  (RD)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: memory image plus a queue of promised responses with due cycles
  logic [31:0] mm [DEPTH];
  exp_t        mq [$];
  exp_t        e;
  int          init_left = INIT_CYC;
  logic        exp_ready;
  logic        exp_valid;
  logic [31:0] a;
  int          w;

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = (INIT_CYC == 1) ? 'x : '0;
  end

  always @(negedge clk) begin
    if (!nrst) begin
      mq.delete();
      init_left = INIT_CYC;
      if (INIT_CYC != 1) for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      chk("m_rst_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("m_rst_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("m_rst_data", bus.resp_data, 32'd0);
      chk("m_rst_err", {31'b0, bus.resp_err}, 32'd0);
    end else begin
      exp_ready = (init_left == 0) && (mq.size() < RD);
      exp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
      chk("m_ready", {31'b0, bus.req_ready}, {31'b0, exp_ready});
      chk("m_valid", {31'b0, bus.resp_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("m_data", bus.resp_data, mq[0].data);
        chk("m_err", {31'b0, bus.resp_err}, {31'b0, mq[0].err});
        if (bus.resp_ready) void'(mq.pop_front());
      end
      if (exp_ready && bus.req_valid) begin
        a     = bus.req_addr;
        e.due = cyc + 1 + LAT;
        if (a >= BASE && a < BASE + DEPTH * 4) begin
          w     = int'((a - BASE) >> 2);
          e.err = 1'b0;
          if (bus.req_we) begin
            for (int b = 0; b < 4; b++) if (bus.req_strb[b]) mm[w][8*b +: 8] = bus.req_data[8*b +: 8];
            e.data = '0;
          end else begin
            e.data = mm[w];
          end
        end else begin
          e.err  = 1'b1;
          e.data = '0;
        end
        mq.push_back(e);
      end
      if (init_left > 0) init_left--;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    bit done = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_strb  = strb;
    bus.req_data  = data;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) done = 1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept: got no accept, expected accept for addr %h", addr);
    end
  endtask

  task automatic get_resp(input string name, input logic [31:0] exp_d, input logic exp_e);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin
        got = 1;
        chk({name, "_data"}, bus.resp_data, exp_d);
        chk({name, "_err"}, {31'b0, bus.resp_err}, {31'b0, exp_e});
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no response, expected data %h", name, exp_d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  int n0;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_strb   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;

    @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 nrst = 1'b1;
    n0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n0++;
    end
    chk("init_cycles", n0, INIT_CYC);
    @(posedge clk);
    #1;
`ifdef LADYBIRD_SRAM_INIT_CLEAR_EN
    do_req(1'b0, BASE + 20, 4'h0, 32'h0);
    get_resp("clr_load", 32'h0, 1'b0);
`endif

    do_req(1'b1, BASE + 8, 4'hF, 32'hDEADBEEF);
    get_resp("st_resp", 32'h0, 1'b0);
    do_req(1'b0, BASE + 8, 4'h0, 32'h0);
    get_resp("ld_beef", 32'hDEADBEEF, 1'b0);

    do_req(1'b1, BASE + 12, 4'hF, 32'h11223344);
    get_resp("st_full", 32'h0, 1'b0);
    do_req(1'b1, BASE + 12, 4'b0101, 32'hAABBCCDD);
    get_resp("st_part", 32'h0, 1'b0);
    do_req(1'b0, BASE + 12, 4'h0, 32'h0);
    get_resp("ld_part", 32'h11BB33DD, 1'b0);

    // back-to-back store then load of the same word
    do_req(1'b1, BASE + 12, 4'hF, 32'h12345678);
    do_req(1'b0, BASE + 12, 4'h0, 32'h0);
    get_resp("raw_st", 32'h0, 1'b0);
    get_resp("raw_ld", 32'h12345678, 1'b0);

    do_req(1'b1, BASE, 4'hF, 32'hCAFEF00D);
    get_resp("st_w0", 32'h0, 1'b0);
    do_req(1'b0, BASE + DEPTH * 4, 4'h0, 32'h0);
    get_resp("oor_ld", 32'h0, 1'b1);
    do_req(1'b1, BASE + DEPTH * 4, 4'hF, 32'hFFFFFFFF);
    get_resp("oor_st", 32'h0, 1'b1);
    do_req(1'b0, BASE - 4, 4'h0, 32'h0);
    get_resp("oor_below", 32'h0, 1'b1);
    do_req(1'b0, BASE, 4'h0, 32'h0);
    get_resp("w0_kept", 32'hCAFEF00D, 1'b0);

    bus.resp_ready = 1'b0;
    do_req(1'b0, BASE, 4'h0, 32'h0);
    do_req(1'b0, BASE + 8, 4'h0, 32'h0);
    @(negedge clk);
    chk("bp_full_ready", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("bp_head_data", bus.resp_data, 32'hCAFEF00D);
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_credit_back", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    get_resp("bp_second", 32'hDEADBEEF, 1'b0);

    bus.resp_ready = 1'b0;
    do_req(1'b0, BASE, 4'h0, 32'h0);
    do_req(1'b0, BASE + 12, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_valid", {31'b0, bus.resp_valid}, 32'd1);
    #1 nrst = 1'b0;
    #1 chk("rst_async_valid", {31'b0, bus.resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    bus.resp_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_stale", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    do_req(1'b0, BASE, 4'h0, 32'h0);
    do_req(1'b0, BASE + 12, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_credits", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
